// File: rtl/issue_ctrl.sv
// Issue controller: pending-register scoreboard, one output register stage,
// and an RUN/DRAIN/FENCE/TRAP FSM for traps and fences.
// Ports:
//   clk, rst_n                  clock, async active-low reset
//   dec_valid/dec_ready         decode handshake; dec_bundle, dec_rd/rs1/rs2 (+_en)
//   alu_/lsu_/csr_valid/ready   per-unit issue handshakes
//   iss_bundle, iss_rd          registered issued instruction
//   wb_valid, wb_rd             writeback completion
//   trap_valid/cause/ack        trap report; fence_req/done; busy
// Option: ISSUE_WB_BYPASS_EN lets a same-cycle writeback wake a dependent
// instruction (hazard check sees pending with wb_rd already cleared).
module issue_ctrl #(
    parameter int MAX_OUT = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        dec_valid,
    output logic        dec_ready,
    input  logic [14:0] dec_bundle,
    input  logic [4:0]  dec_rd,
    input  logic [4:0]  dec_rs1,
    input  logic [4:0]  dec_rs2,
    input  logic        dec_rd_en,
    input  logic        dec_rs1_en,
    input  logic        dec_rs2_en,
    output logic        alu_valid,
    input  logic        alu_ready,
    output logic        lsu_valid,
    input  logic        lsu_ready,
    output logic        csr_valid,
    input  logic        csr_ready,
    output logic [14:0] iss_bundle,
    output logic [4:0]  iss_rd,
    input  logic        wb_valid,
    input  logic [4:0]  wb_rd,
    output logic        trap_valid,
    output logic [1:0]  trap_cause,
    input  logic        trap_ack,
    output logic        fence_req,
    input  logic        fence_done,
    output logic        busy
);

    localparam int CW = 4;

    typedef enum logic [1:0] {
        S_RUN,
        S_DRAIN,
        S_FENCE,
        S_TRAP
    } state_e;

    state_e        state_q;
    logic [31:0]   pend_q, pend_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          ov_q;
    logic [14:0]   ob_q;
    logic [4:0]    ord_q;
    logic          tv_q, fr_q;
    logic [1:0]    cause_q;
    logic          op_ill_q, op_ecall_q, op_ebreak_q, op_fi_q;

    logic [31:0]   wb_mask, set_mask, pend_chk;
    logic          is_csr, is_lsu, is_alu;
    logic          fire, wb_ok, rd_wr, cnt_full;
    logic          haz, accept, special, inc;

    // Unit routing: the csr bit wins over the unit field.
    assign is_csr = ob_q[4];
    assign is_lsu = !ob_q[4] && (ob_q[14:13] == 2'd1);
    assign is_alu = !is_csr && !is_lsu;

    assign alu_valid = ov_q && is_alu;
    assign lsu_valid = ov_q && is_lsu;
    assign csr_valid = ov_q && is_csr;

    assign fire = (alu_valid && alu_ready)
               || (lsu_valid && lsu_ready)
               || (csr_valid && csr_ready);

    // A writeback with nothing outstanding is dropped entirely.
    assign wb_ok   = wb_valid && (cnt_q != '0);
    assign wb_mask = wb_ok ? (32'd1 << wb_rd) : 32'd0;

`ifdef ISSUE_WB_BYPASS_EN
    assign pend_chk = pend_q & ~wb_mask;
`else
    assign pend_chk = pend_q;
`endif

    assign rd_wr    = dec_rd_en && (dec_rd != 5'd0);
    assign cnt_full = (cnt_q == CW'(MAX_OUT));

    assign haz = (dec_rs1_en && pend_chk[dec_rs1])
              || (dec_rs2_en && pend_chk[dec_rs2])
              || (dec_rd_en && pend_chk[dec_rd])
              || (rd_wr && cnt_full);

    assign dec_ready = rst_n && (state_q == S_RUN)
                    && (!ov_q || fire) && !haz;

    assign accept  = dec_valid && dec_ready;
    assign special = |dec_bundle[3:0];

    // Trap/fence bundles never reach a unit, so they never claim rd.
    assign inc      = accept && !special && rd_wr;
    assign set_mask = inc ? (32'd1 << dec_rd) : 32'd0;

    // Clear before set: a same-cycle set of the same index wins.
    assign pend_d = ((pend_q & ~wb_mask) | set_mask) & 32'hFFFF_FFFE;

    always_comb begin
        cnt_d = cnt_q;
        if (inc && !wb_ok) begin
            cnt_d = cnt_q + CW'(1);
        end else if (!inc && wb_ok) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    assign iss_bundle = ob_q;
    assign iss_rd     = ord_q;
    assign trap_valid = tv_q;
    assign trap_cause = cause_q;
    assign fence_req  = fr_q;
    assign busy = (state_q != S_RUN) || (cnt_q != '0) || ov_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_RUN;
            pend_q      <= '0;
            cnt_q       <= '0;
            ov_q        <= 1'b0;
            ob_q        <= '0;
            ord_q       <= '0;
            tv_q        <= 1'b0;
            fr_q        <= 1'b0;
            cause_q     <= '0;
            op_ill_q    <= 1'b0;
            op_ecall_q  <= 1'b0;
            op_ebreak_q <= 1'b0;
            op_fi_q     <= 1'b0;
        end else begin
            pend_q <= pend_d;
            cnt_q  <= cnt_d;

            if (accept && !special) begin
                ov_q  <= 1'b1;
                ob_q  <= dec_bundle;
                ord_q <= dec_rd;
            end else if (fire) begin
                ov_q <= 1'b0;
            end

            unique case (state_q)
                S_RUN: begin
                    if (accept && special) begin
                        state_q     <= S_DRAIN;
                        op_ill_q    <= dec_bundle[0];
                        op_ecall_q  <= dec_bundle[2];
                        op_ebreak_q <= dec_bundle[1];
                        op_fi_q     <= dec_bundle[3] && dec_bundle[5];
                    end
                end
                S_DRAIN: begin
                    if ((cnt_q == '0) && !ov_q) begin
                        if (op_ill_q) begin
                            state_q <= S_TRAP;
                            tv_q    <= 1'b1;
                            cause_q <= 2'd0;
                        end else if (op_ecall_q) begin
                            state_q <= S_TRAP;
                            tv_q    <= 1'b1;
                            cause_q <= 2'd1;
                        end else if (op_ebreak_q) begin
                            state_q <= S_TRAP;
                            tv_q    <= 1'b1;
                            cause_q <= 2'd2;
                        end else if (op_fi_q) begin
                            state_q <= S_FENCE;
                            fr_q    <= 1'b1;
                        end else begin
                            state_q <= S_RUN;
                        end
                    end
                end
                S_FENCE: begin
                    if (fence_done) begin
                        state_q <= S_RUN;
                        fr_q    <= 1'b0;
                    end
                end
                S_TRAP: begin
                    if (trap_ack) begin
                        state_q <= S_RUN;
                        tv_q    <= 1'b0;
                    end
                end
                default: state_q <= S_RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_issue_ctrl.sv
// Self-checking bench for issue_ctrl: directed scenarios plus a randomized
// run against a queue-based model of outstanding register writes.
module tb_issue_ctrl;

    localparam int MAX_OUT = 4;
`ifdef ISSUE_WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        dec_valid, dec_ready;
    logic [14:0] dec_bundle;
    logic [4:0]  dec_rd, dec_rs1, dec_rs2;
    logic        dec_rd_en, dec_rs1_en, dec_rs2_en;
    logic        alu_valid, alu_ready, lsu_valid, lsu_ready;
    logic        csr_valid, csr_ready;
    logic [14:0] iss_bundle;
    logic [4:0]  iss_rd;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic        trap_valid, trap_ack;
    logic [1:0]  trap_cause;
    logic        fence_req, fence_done, busy;

    int n_cmp = 0;
    int n_fail = 0;

    logic [4:0] outq[$];

    issue_ctrl #(.MAX_OUT(MAX_OUT)) dut (
        .clk(clk), .rst_n(rst_n),
        .dec_valid(dec_valid), .dec_ready(dec_ready),
        .dec_bundle(dec_bundle),
        .dec_rd(dec_rd), .dec_rs1(dec_rs1), .dec_rs2(dec_rs2),
        .dec_rd_en(dec_rd_en), .dec_rs1_en(dec_rs1_en),
        .dec_rs2_en(dec_rs2_en),
        .alu_valid(alu_valid), .alu_ready(alu_ready),
        .lsu_valid(lsu_valid), .lsu_ready(lsu_ready),
        .csr_valid(csr_valid), .csr_ready(csr_ready),
        .iss_bundle(iss_bundle), .iss_rd(iss_rd),
        .wb_valid(wb_valid), .wb_rd(wb_rd),
        .trap_valid(trap_valid), .trap_cause(trap_cause),
        .trap_ack(trap_ack),
        .fence_req(fence_req), .fence_done(fence_done),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in;
        dec_valid  = 1'b0;
        dec_bundle = '0;
        dec_rd     = '0;
        dec_rs1    = '0;
        dec_rs2    = '0;
        dec_rd_en  = 1'b0;
        dec_rs1_en = 1'b0;
        dec_rs2_en = 1'b0;
        wb_valid   = 1'b0;
        wb_rd      = '0;
        trap_ack   = 1'b0;
        fence_done = 1'b0;
    endtask

    task automatic put(input logic [14:0] b, input logic [4:0] rd,
                       input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic rde, input logic r1e, input logic r2e);
        dec_valid  = 1'b1;
        dec_bundle = b;
        dec_rd     = rd;
        dec_rs1    = rs1;
        dec_rs2    = rs2;
        dec_rd_en  = rde;
        dec_rs1_en = r1e;
        dec_rs2_en = r2e;
    endtask

    task automatic wb(input logic [4:0] r);
        wb_valid = 1'b1;
        wb_rd    = r;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        put(15'h0040, 5'd3, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1);
        #1;
        n_cmp++;
        if ({dec_ready, alu_valid, lsu_valid, csr_valid,
             trap_valid, fence_req, busy} !== 7'b0) begin
            n_fail++;
            $display("FAIL reset_ctl got %b want 0000000",
                {dec_ready, alu_valid, lsu_valid, csr_valid,
                 trap_valid, fence_req, busy});
        end
        n_cmp++;
        if ({iss_bundle, iss_rd} !== 20'h0) begin
            n_fail++;
            $display("FAIL reset_iss got %h want 0", {iss_bundle, iss_rd});
        end
        step;
        rst_n = 1'b1;
        idle_in();
        #1;
        n_cmp++;
        if ({dec_ready, busy} !== 2'b10) begin
            n_fail++;
            $display("FAIL reset_rel got %b want 10", {dec_ready, busy});
        end
        step;
    endtask

    task automatic test_raw;
        put(15'h0040, 5'd5, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0);
        #1;
        n_cmp++;
        if (dec_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL raw_first got %b want 1", dec_ready);
        end
        step;
        put(15'h0000, 5'd6, 5'd5, 5'd0, 1'b1, 1'b1, 1'b0);
        #1;
        n_cmp++;
        if ({dec_ready, alu_valid, iss_rd} !== {2'b01, 5'd5}) begin
            n_fail++;
            $display("FAIL raw_issue got %b want 0100101",
                {dec_ready, alu_valid, iss_rd});
        end
        for (int i = 0; i < 2; i++) begin
            step;
            n_cmp++;
            if (dec_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL raw_stall got %b want 0", dec_ready);
            end
        end
        wb(5'd5);
        #1;
        n_cmp++;
        if (dec_ready !== BYP) begin
            n_fail++;
            $display("FAIL raw_wb_cycle got %b want %b", dec_ready, BYP);
        end
        step;
        wb_valid = 1'b0;
        #1;
        n_cmp++;
        if (dec_ready !== !BYP) begin
            n_fail++;
            $display("FAIL raw_after_wb got %b want %b", dec_ready, !BYP);
        end
        step;
        dec_valid = 1'b0;
        #1;
        n_cmp++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL raw_busy got %b want 1", busy);
        end
        wb(5'd6);
        step;
        wb_valid = 1'b0;
        step;
        n_cmp++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL raw_idle got %b want 0", busy);
        end
    endtask

    task automatic test_max_out;
        for (int r = 1; r <= MAX_OUT; r++) begin
            put(15'h0000, 5'(r), 5'd0, 5'd0, 1'b1, 1'b0, 1'b0);
            #1;
            n_cmp++;
            if (dec_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL maxout_acc%0d got %b want 1", r, dec_ready);
            end
            step;
        end
        put(15'h0000, 5'd5, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            if (i == 2) wb(5'd1);
            #1;
            n_cmp++;
            if (dec_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL maxout_stall%0d got %b want 0", i, dec_ready);
            end
            step;
        end
        wb_valid = 1'b0;
        #1;
        n_cmp++;
        if (dec_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL maxout_fifth got %b want 1", dec_ready);
        end
        step;
        dec_valid = 1'b0;
        for (int r = 2; r <= 5; r++) begin
            wb(5'(r));
            step;
        end
        wb_valid = 1'b0;
        step;
        n_cmp++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL maxout_idle got %b want 0", busy);
        end
    endtask

    task automatic test_lsu_stall;
        lsu_ready = 1'b0;
        put(15'h2140, 5'd7, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0);
        #1;
        n_cmp++;
        if (dec_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL lsu_acc got %b want 1", dec_ready);
        end
        step;
        put(15'h0080, 5'd8, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) begin
            #1;
            n_cmp++;
            if ({lsu_valid, alu_valid, csr_valid, dec_ready} !== 4'b1000) begin
                n_fail++;
                $display("FAIL lsu_hold%0d got %b want 1000", i,
                    {lsu_valid, alu_valid, csr_valid, dec_ready});
            end
            n_cmp++;
            if ({iss_bundle, iss_rd} !== {15'h2140, 5'd7}) begin
                n_fail++;
                $display("FAIL lsu_stable%0d got %h want %h", i,
                    {iss_bundle, iss_rd}, {15'h2140, 5'd7});
            end
            step;
        end
        lsu_ready = 1'b1;
        #1;
        n_cmp++;
        if (dec_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL lsu_release got %b want 1", dec_ready);
        end
        step;
        dec_valid = 1'b0;
        #1;
        n_cmp++;
        if ({alu_valid, iss_bundle} !== {1'b1, 15'h0080}) begin
            n_fail++;
            $display("FAIL lsu_next got %h want %h",
                {alu_valid, iss_bundle}, {1'b1, 15'h0080});
        end
        wb(5'd7);
        step;
        wb(5'd8);
        step;
        wb_valid = 1'b0;
        step;
        n_cmp++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL lsu_idle got %b want 0", busy);
        end
    endtask

    task automatic test_ecall_drain;
        int k;
        put(15'h0000, 5'd10, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0);
        step;
        put(15'h0000, 5'd11, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0);
        step;
        put(15'h0004, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        #1;
        n_cmp++;
        if (dec_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL ecall_acc got %b want 1", dec_ready);
        end
        step;
        put(15'h0000, 5'd20, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            if (i == 2) wb(5'd10);
            if (i == 3) wb(5'd11);
            #1;
            n_cmp++;
            if ({dec_ready, trap_valid, busy} !== 3'b001) begin
                n_fail++;
                $display("FAIL ecall_drain%0d got %b want 001", i,
                    {dec_ready, trap_valid, busy});
            end
            step;
        end
        idle_in();
        k = 0;
        while (trap_valid !== 1'b1 && k < 20) begin
            step;
            k++;
        end
        for (int i = 0; i < 3; i++) begin
            #1;
            n_cmp++;
            if ({trap_valid, trap_cause, dec_ready} !== 4'b1010) begin
                n_fail++;
                $display("FAIL ecall_trap%0d got %b want 1010", i,
                    {trap_valid, trap_cause, dec_ready});
            end
            step;
        end
        trap_ack = 1'b1;
        step;
        trap_ack = 1'b0;
        #1;
        n_cmp++;
        if ({trap_valid, busy, dec_ready} !== 3'b001) begin
            n_fail++;
            $display("FAIL ecall_run got %b want 001",
                {trap_valid, busy, dec_ready});
        end
        step;
    endtask

    task automatic test_fence;
        int k;
        bit seen;
        logic [14:0] tb_b [3];
        logic [1:0]  tb_c [3];
        tb_b[0] = 15'h0005; tb_c[0] = 2'd0;
        tb_b[1] = 15'h0002; tb_c[1] = 2'd2;
        tb_b[2] = 15'h0006; tb_c[2] = 2'd1;
        put(15'h0028, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        step;
        dec_valid = 1'b0;
        k = 0;
        while (fence_req !== 1'b1 && k < 20) begin
            step;
            k++;
        end
        for (int i = 0; i < 3; i++) begin
            #1;
            n_cmp++;
            if ({fence_req, busy, trap_valid, dec_ready} !== 4'b1100) begin
                n_fail++;
                $display("FAIL fencei_hold%0d got %b want 1100", i,
                    {fence_req, busy, trap_valid, dec_ready});
            end
            step;
        end
        fence_done = 1'b1;
        step;
        fence_done = 1'b0;
        #1;
        n_cmp++;
        if ({fence_req, busy} !== 2'b00) begin
            n_fail++;
            $display("FAIL fencei_done got %b want 00", {fence_req, busy});
        end
        step;
        put(15'h0008, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        step;
        dec_valid = 1'b0;
        seen = 1'b0;
        k = 0;
        while (busy !== 1'b0 && k < 20) begin
            seen |= fence_req | trap_valid;
            step;
            k++;
        end
        n_cmp++;
        if ({busy, seen} !== 2'b00) begin
            n_fail++;
            $display("FAIL fence_plain got %b want 00", {busy, seen});
        end
        for (int t = 0; t < 3; t++) begin
            put(tb_b[t], 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
            step;
            dec_valid = 1'b0;
            k = 0;
            while (trap_valid !== 1'b1 && k < 20) begin
                step;
                k++;
            end
            n_cmp++;
            if ({trap_valid, trap_cause} !== {1'b1, tb_c[t]}) begin
                n_fail++;
                $display("FAIL cause_%h got %b want %b", tb_b[t],
                    {trap_valid, trap_cause}, {1'b1, tb_c[t]});
            end
            trap_ack = 1'b1;
            step;
            trap_ack = 1'b0;
        end
        step;
    endtask

    task automatic test_reset_abort;
        int k;
        bit seen;
        put(15'h0000, 5'd12, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0);
        step;
        put(15'h0004, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        step;
        dec_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({busy, trap_valid, dec_ready} !== 3'b000) begin
            n_fail++;
            $display("FAIL rst_drain got %b want 000",
                {busy, trap_valid, dec_ready});
        end
        step;
        rst_n = 1'b1;
        put(15'h0000, 5'd13, 5'd12, 5'd0, 1'b1, 1'b1, 1'b0);
        #1;
        n_cmp++;
        if ({dec_ready, busy} !== 2'b10) begin
            n_fail++;
            $display("FAIL rst_pend_clr got %b want 10", {dec_ready, busy});
        end
        step;
        dec_valid = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            seen |= trap_valid | fence_req;
            step;
        end
        wb(5'd13);
        step;
        wb_valid = 1'b0;
        step;
        n_cmp++;
        if ({busy, seen} !== 2'b00) begin
            n_fail++;
            $display("FAIL rst_no_trap got %b want 00", {busy, seen});
        end
        put(15'h0028, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        step;
        dec_valid = 1'b0;
        k = 0;
        while (fence_req !== 1'b1 && k < 20) begin
            step;
            k++;
        end
        n_cmp++;
        if (fence_req !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_fence_enter got %b want 1", fence_req);
        end
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({fence_req, busy} !== 2'b00) begin
            n_fail++;
            $display("FAIL rst_fence_drop got %b want 00", {fence_req, busy});
        end
        step;
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            seen |= trap_valid | fence_req | busy;
            step;
        end
        n_cmp++;
        if (seen !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_fence_after got %b want 0", seen);
        end
    endtask

    function automatic bit is_pend(input logic [4:0] r);
        if (BYP && wb_valid && r == wb_rd) return 1'b0;
        foreach (outq[i]) if (outq[i] == r) return 1'b1;
        return 1'b0;
    endfunction

    task automatic test_random;
        bit mov = 1'b0;
        logic [14:0] mb = '0;
        logic [4:0] mrd = '0;
        int tgt, wi;
        bit haz, fire, exp_rdy;
        logic [4:0] ev;
        outq.delete();
        for (int c = 0; c < 400; c++) begin
            dec_valid  = 1'($urandom % 2);
            dec_bundle = 15'($urandom) & 15'h7FF0;
            dec_rd     = 5'($urandom % 8);
            dec_rs1    = 5'($urandom % 8);
            dec_rs2    = 5'($urandom % 8);
            dec_rd_en  = 1'($urandom % 2);
            dec_rs1_en = 1'($urandom % 2);
            dec_rs2_en = 1'($urandom % 2);
            alu_ready  = ($urandom % 4) != 0;
            lsu_ready  = ($urandom % 4) != 0;
            csr_ready  = ($urandom % 4) != 0;
            wb_valid = 1'b0;
            wb_rd    = 5'($urandom % 32);
            wi = -1;
            if (outq.size() > 0 && $urandom % 3 == 0) begin
                wi = int'($urandom % outq.size());
                wb(outq[wi]);
            end else if (outq.size() == 0 && $urandom % 4 == 0) begin
                wb_valid = 1'b1;
            end
            tgt  = mb[4] ? 2 : (mb[14:13] == 2'd1 ? 1 : 0);
            fire = mov && ((tgt == 0 && alu_ready) || (tgt == 1 && lsu_ready)
                        || (tgt == 2 && csr_ready));
            haz = (dec_rs1_en && is_pend(dec_rs1))
               || (dec_rs2_en && is_pend(dec_rs2))
               || (dec_rd_en && is_pend(dec_rd))
               || (dec_rd_en && dec_rd != 0 && outq.size() == MAX_OUT);
            exp_rdy = (!mov || fire) && !haz;
            ev = {exp_rdy, mov && tgt == 0, mov && tgt == 1, mov && tgt == 2,
                  mov || outq.size() > 0};
            #1;
            n_cmp++;
            if ({dec_ready, alu_valid, lsu_valid, csr_valid, busy} !== ev) begin
                n_fail++;
                $display("FAIL rand_ctl cyc%0d got %b want %b", c,
                    {dec_ready, alu_valid, lsu_valid, csr_valid, busy}, ev);
            end
            if (mov) begin
                n_cmp++;
                if ({iss_bundle, iss_rd} !== {mb, mrd}) begin
                    n_fail++;
                    $display("FAIL rand_iss cyc%0d got %h want %h", c,
                        {iss_bundle, iss_rd}, {mb, mrd});
                end
            end
            step;
            if (wi >= 0) outq.delete(wi);
            if (dec_valid && exp_rdy) begin
                if (dec_rd_en && dec_rd != 0) outq.push_back(dec_rd);
                mov = 1'b1;
                mb  = dec_bundle;
                mrd = dec_rd;
            end else if (fire) begin
                mov = 1'b0;
            end
        end
        idle_in();
        alu_ready = 1'b1;
        lsu_ready = 1'b1;
        csr_ready = 1'b1;
        while (outq.size() > 0) begin
            wb(outq.pop_front());
            step;
        end
        wb_valid = 1'b0;
        step;
        step;
        n_cmp++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL rand_idle got %b want 0", busy);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        alu_ready = 1'b1;
        lsu_ready = 1'b1;
        csr_ready = 1'b1;
        idle_in();
        test_reset();
        test_raw();
        idle_in();
        test_max_out();
        idle_in();
        test_lsu_stall();
        idle_in();
        test_ecall_drain();
        idle_in();
        test_fence();
        idle_in();
        test_reset_abort();
        idle_in();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
